fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the PC, the PC+2 adder, the branch/jump redirect mux and the IF/ID pipeline buffer.
- Adds a halt sequencer that drains the pipeline before freezing.
- Feeds ID with id_instruction / id_pc_next_address. Takes stall, flush, branch and halt controls from the hazard unit and control unit.

Parameters:
- DATA_W, 16: instruction and address width.
- RESET_PC, 16'h0000: PC value after reset.
- NOP_INSTR, 16'h0000: encoding injected on flush, stall-bubble and drain.
- DRAIN_CYCLES, 3: NOP cycles issued after halt_req before entering HALTED.

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- imem_addr, out, DATA_W: instruction-memory address; equals the PC register (combinational from PC).
- imem_rdata, in, DATA_W: instruction word returned combinationally for imem_addr.
- pc_stop, in, 1: hazard-unit stall; hold PC and the IF/ID buffer.
- if_id_flush, in, 1: replace the IF/ID contents with a NOP next edge.
- branch_taken, in, 1: redirect the PC to branch_target.
- branch_target, in, DATA_W: redirect address; bit 0 is forced to 0.
- halt_req, in, 1: single-cycle pulse from the control unit on a HALT opcode.
- id_instruction, out, DATA_W: IF/ID buffer instruction.
- id_pc_next_address, out, DATA_W: IF/ID buffer copy of PC+2 for the latched instruction.
- id_valid, out, 1: 1 when id_instruction is a real fetched instruction (0 for a bubble or NOP).
- halted, out, 1: 1 in the HALTED state.
- fetch_count, out, 16: number of valid instructions latched into IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any time, including mid-drain):
  - PC = RESET_PC; id_instruction = NOP_INSTR; id_pc_next_address = 0.
  - id_valid = 0; halted = 0; fetch_count = 0; drain counter = 0; FSM = RUN.
- Adder: pc_plus2 = PC + 2, modulo 2^16. 16'hFFFE wraps to 16'h0000; no flag.
- FSM states:
  - RUN: normal fetch.
  - DRAIN: issue NOPs; PC frozen.
  - HALTED: frozen.
- RUN priority per edge (highest first):
  1. halt_req: go to DRAIN, drain counter = DRAIN_CYCLES-1. PC holds. IF/ID = NOP, id_valid = 0.
  2. branch_taken: PC = {branch_target[15:1],1'b0}. IF/ID = NOP, id_valid = 0. Branch overrides pc_stop and if_id_flush.
  3. pc_stop: PC and the IF/ID buffer hold their values. fetch_count does not change. If if_id_flush is also 1, IF/ID = NOP and id_valid = 0; PC still holds.
  4. if_id_flush alone: PC = pc_plus2; IF/ID = NOP; id_valid = 0.
  5. Otherwise: PC = pc_plus2; id_instruction = imem_rdata; id_pc_next_address = pc_plus2; id_valid = 1; fetch_count += 1 (saturating).
- DRAIN:
  - IF/ID = NOP, id_valid = 0, PC holds each cycle.
  - branch_taken, pc_stop, if_id_flush and halt_req are ignored.
  - Counter decrements; when it reaches 0 the next state is HALTED.
  - Total NOP cycles after the halt_req edge is DRAIN_CYCLES.
- HALTED: halted = 1. PC, IF/ID (NOP) and fetch_count are frozen. All inputs are ignored. Only reset exits this state.
- Latency: an instruction at address A appears on id_instruction one edge after PC = A, with no stall.
- imem_addr changes only on PC updates; no glitch requirement beyond that.

Test Plan:
- Reset release, imem returns 16'h1000+addr, no stalls: after 4 edges PC = 16'h0008. id_instruction = 16'h1006, id_pc_next_address = 16'h0008, fetch_count = 4, id_valid = 1.
- Stall: pc_stop = 1 for 2 cycles while PC = 16'h0004. PC stays 16'h0004. id_instruction holds 16'h1002, fetch_count holds. Release resumes fetch at 16'h0004.
- Branch: branch_taken = 1, branch_target = 16'h0031, with pc_stop = 1 the same cycle. Next edge: PC = 16'h0030, id_instruction = NOP, id_valid = 0. Following edge: id_instruction = 16'h1030.
- Wrap: RESET_PC forced via branch to 16'hFFFE. Next edge: PC = 16'h0000, id_pc_next_address = 16'h0000.
- Halt: halt_req pulse at PC = 16'h0010. Exactly 3 NOP cycles follow, then halted = 1. A branch_taken during DRAIN is ignored; PC stays 16'h0010 indefinitely.
- Async reset asserted mid-DRAIN between clock edges: outputs reach reset values immediately. FSM = RUN, halted = 0, and fetch restarts at 16'h0000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage (PC, PC+2, redirect, IF/ID buffer, halt drain) | clock/reset, imem_addr/imem_rdata, pc_stop/if_id_flush/branch_*/halt_req in, id_*/halted/fetch_count out
module fetch_stage #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              pc_stop,
  input  logic              if_id_flush,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              halt_req,
  output logic [DATA_W-1:0] id_instruction,
  output logic [DATA_W-1:0] id_pc_next_address,
  output logic              id_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;
  logic [DATA_W-1:0] pc, pc_plus2, target;
  logic [7:0] drain_cnt;
  assign pc_plus2 = pc + DATA_W'(2);
  assign target = {branch_target[DATA_W-1:1], 1'b0};
  assign imem_addr = pc;
  assign halted = state == HALTED;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      id_instruction <= NOP_INSTR;
      id_pc_next_address <= '0;
      id_valid <= 1'b0;
      fetch_count <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state <= DRAIN;
            drain_cnt <= 8'(DRAIN_CYCLES - 1);
            id_instruction <= NOP_INSTR;
            id_valid <= 1'b0;
          end else if (branch_taken) begin
            pc <= target;
            id_instruction <= NOP_INSTR;
            id_valid <= 1'b0;
          end else if (pc_stop) begin
            if (if_id_flush) begin
              id_instruction <= NOP_INSTR;
              id_valid <= 1'b0;
            end
          end else if (if_id_flush) begin
            pc <= pc_plus2;
            id_instruction <= NOP_INSTR;
            id_valid <= 1'b0;
          end else begin
            pc <= pc_plus2;
            id_instruction <= imem_rdata;
            id_pc_next_address <= pc_plus2;
            id_valid <= 1'b1;
            fetch_count <= fetch_count == 16'hFFFF ? fetch_count : fetch_count + 16'd1;
          end
        end
        DRAIN: begin
          id_instruction <= NOP_INSTR;
          id_valid <= 1'b0;
          if (drain_cnt == 8'd0) state <= HALTED;
          else drain_cnt <= drain_cnt - 8'd1;
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end
endmodule
